// File: rtl/avalon_pio_ext.sv
// Avalon-MM PIO slave: output register with atomic set/clear and a blink engine,
// synchronised input port with edge capture and a maskable level interrupt.
`timescale 1ns/1ps
module avalon_pio_ext #(
  parameter int unsigned           OUT_WIDTH   = 14,
  parameter int unsigned           IN_WIDTH    = 4,
  parameter logic [OUT_WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned           EDGE_TYPE   = 0,
  parameter int unsigned           BLINK_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  typedef enum logic [2:0] {
    REG_DATA      = 3'd0,
    REG_INPUT     = 3'd1,
    REG_IRQMASK   = 3'd2,
    REG_EDGECAP   = 3'd3,
    REG_OUTSET    = 3'd4,
    REG_OUTCLR    = 3'd5,
    REG_BLINKMASK = 3'd6,
    REG_BLINKPER  = 3'd7
  } reg_addr_e;

  logic [OUT_WIDTH-1:0]   data_out_q, data_out_d;
  logic [IN_WIDTH-1:0]    in_meta_q, in_sync_q, in_prev_q;
  logic [IN_WIDTH-1:0]    edge_cap_q, edge_cap_d;
  logic [IN_WIDTH-1:0]    irq_mask_q, irq_mask_d;
  logic [OUT_WIDTH-1:0]   blink_mask_q, blink_mask_d;
  logic [BLINK_WIDTH-1:0] blink_period_q, blink_period_d;
  logic [BLINK_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;

  reg_addr_e              addr;
  logic                   wr;
  logic [IN_WIDTH-1:0]    rise, fall, edge_det, clr;
  logic [OUT_WIDTH-1:0]   wd_out;
  logic [IN_WIDTH-1:0]    wd_in;
  logic [BLINK_WIDTH-1:0] wd_blink;
  logic                   unused_wd;

  assign addr      = reg_addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign wd_out    = writedata[OUT_WIDTH-1:0];
  assign wd_in     = writedata[IN_WIDTH-1:0];
  assign wd_blink  = writedata[BLINK_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    rise     = in_sync_q & ~in_prev_q;
    fall     = ~in_sync_q & in_prev_q;
    edge_det = rise | fall;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  always_comb begin
    data_out_d     = data_out_q;
    irq_mask_d     = irq_mask_q;
    blink_mask_d   = blink_mask_q;
    blink_period_d = blink_period_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    clr            = '0;

    if (blink_period_q == '0) begin
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == '0) begin
      blink_cnt_d   = blink_period_q;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q - BLINK_WIDTH'(1);
    end

    if (wr) begin
      case (addr)
        REG_DATA:      data_out_d   = wd_out;
        REG_IRQMASK:   irq_mask_d   = wd_in;
        REG_EDGECAP:   clr          = wd_in;
        REG_OUTSET:    data_out_d   = data_out_q | wd_out;
        REG_OUTCLR:    data_out_d   = data_out_q & ~wd_out;
        REG_BLINKMASK: blink_mask_d = wd_out;
        // Period write restarts the countdown, taking priority over the engine.
        REG_BLINKPER: begin
          blink_period_d = wd_blink;
          blink_cnt_d    = wd_blink;
          blink_phase_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // A new edge in the same cycle as its W1C clear keeps the bit set.
    edge_cap_d = (edge_cap_q & ~clr) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q     <= RESET_VALUE;
      in_meta_q      <= '0;
      in_sync_q      <= '0;
      in_prev_q      <= '0;
      edge_cap_q     <= '0;
      irq_mask_q     <= '0;
      blink_mask_q   <= '0;
      blink_period_q <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
    end else begin
      data_out_q     <= data_out_d;
      in_meta_q      <= in_port;
      in_sync_q      <= in_meta_q;
      in_prev_q      <= in_sync_q;
      edge_cap_q     <= edge_cap_d;
      irq_mask_q     <= irq_mask_d;
      blink_mask_q   <= blink_mask_d;
      blink_period_q <= blink_period_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (addr)
      REG_DATA:      readdata = 32'(data_out_q);
      REG_INPUT:     readdata = 32'(in_sync_q);
      REG_IRQMASK:   readdata = 32'(irq_mask_q);
      REG_EDGECAP:   readdata = 32'(edge_cap_q);
      REG_BLINKMASK: readdata = 32'(blink_mask_q);
      REG_BLINKPER:  readdata = 32'(blink_period_q);
      default:       readdata = '0;
    endcase
  end

  assign out_port = data_out_q ^ (blink_mask_q & {OUT_WIDTH{blink_phase_q}});
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: doc/avalon_pio_ext.md
Name: avalon_pio_ext

Overview:
- Parametrised Avalon-MM slave PIO, the next generation of the single-register LED output port.
- Adds:
  - configurable output and input widths
  - atomic bit set and clear
  - a synchronised input port with edge capture and a maskable level interrupt
  - a hardware blink engine that toggles selected output bits at a programmable period
- Sits on the Nios II system interconnect; drives LEDs/hex segments and samples keys/switches.

Parameters:
- OUT_WIDTH, 14, width of out_port and output data register (1..32).
- IN_WIDTH, 4, width of in_port (1..32).
- RESET_VALUE, 0, reset value of the output data register (OUT_WIDTH bits).
- EDGE_TYPE, 0, edge-capture type: 0 rising, 1 falling, 2 any.
- BLINK_WIDTH, 24, width of blink period register and counter (1..32).

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states; unused upper bits 0.
- in_port  in  IN_WIDTH  asynchronous external inputs.
- out_port  out  OUT_WIDTH  output pins.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset (asynchronous, reset_n=0) forces:
  - data_out=RESET_VALUE
  - in_meta, in_sync and in_prev = 0
  - edge_cap, irq_mask, blink_mask = 0
  - blink_period, blink_cnt = 0; blink_phase = 0
- Resulting outputs at reset: out_port=RESET_VALUE, irq=0, readdata reflects register state.
- Write = chipselect & ~write_n; takes effect on the next clk edge.
- Register map, word addresses:
  - 0 DATA (R/W): write data_out<=writedata[OUT_WIDTH-1:0]; read data_out.
  - 1 INPUT (RO): read in_sync; writes ignored.
  - 2 IRQMASK (R/W): IN_WIDTH bits.
  - 3 EDGECAP (R/W1C): read edge_cap; writing 1 to a bit clears it.
  - 4 OUTSET (WO): data_out<=data_out | wd; reads 0.
  - 5 OUTCLR (WO): data_out<=data_out & ~wd; reads 0.
  - 6 BLINKMASK (R/W): OUT_WIDTH bits.
  - 7 BLINKPER (R/W): BLINK_WIDTH bits. A write also loads blink_cnt with the new value and clears blink_phase.
- Read path: readdata = zero-extended selected register, purely combinational from address. chipselect is not required for reads.
- Input path:
  - in_meta<=in_port; in_sync<=in_meta; in_prev<=in_sync.
  - Synchroniser latency: 2 clocks from pin to INPUT register.
- Edge detect:
  - rise = in_sync & ~in_prev; fall = ~in_sync & in_prev; edge = selected by EDGE_TYPE.
  - Edge is visible in EDGECAP 3 clocks after the pin changes.
  - edge_cap <= (edge_cap & ~clr) | edge. A set in the same cycle as a W1C clear of the same bit wins: the bit stays 1.
- irq = |(edge_cap & irq_mask), combinational from registers. No extra latency after EDGECAP/IRQMASK update.
- Blink engine:
  - blink_period==0: engine idle, blink_cnt holds, blink_phase held 0.
  - Otherwise each clock: if blink_cnt==0, blink_cnt<=blink_period and blink_phase toggles; else blink_cnt<=blink_cnt-1.
  - Phase half-period = blink_period+1 clocks; full blink period = 2*(blink_period+1) clocks.
  - A BLINKPER write overrides the countdown in that cycle.
- out_port = data_out ^ (blink_mask & {OUT_WIDTH{blink_phase}}). Registered sources only, so out_port is glitch-free.
- DATA reads return data_out, not the blinked pin value.
- Writes to OUTSET/OUTCLR use writedata[OUT_WIDTH-1:0]; bits above the register width are ignored everywhere.
- Reset mid-operation: all state returns to reset values immediately, regardless of clock. Pending edges are lost.

Test Plan:
- Reset then read: with RESET_VALUE=14'h0000, read addr 0 -> 0 and out_port=0, irq=0. Write addr 0 = 32'hFFFF_FFFF -> out_port=14'h3FFF, read addr 0 = 32'h0000_3FFF.
- Set/clear: from data_out=14'h00F0, write OUTSET=14'h0003 -> 14'h00F3. Then OUTCLR=14'h0030 -> 14'h00C3. Reads of addr 4/5 return 0.
- Edge/irq: EDGE_TYPE=0, IRQMASK=4'b0010, drive in_port[1] 0->1 -> EDGECAP=4'b0010 on the 3rd clock and irq=1. Drive in_port[0] 0->1 -> EDGECAP=4'b0011, irq still 1. W1C 4'b0010 -> EDGECAP=4'b0001, irq=0.
- Set beats clear: arrange the in_port[2] rising edge to detect in the same cycle as a W1C of bit 2 -> EDGECAP[2]=1 afterwards.
- Blink: data_out=0, BLINKMASK=14'h0001, BLINKPER=3 -> out_port[0] toggles every 4 clocks (period 8); other bits stay 0. Write BLINKPER=0 -> out_port[0]=0 from the next clock and stays.
- Async reset: assert reset_n low mid-blink with EDGECAP nonzero -> out_port=RESET_VALUE, irq=0, all registers read 0 within the reset pulse, without a clock edge.
